// File: rtl/seq_driver_if.sv
// -----------------------------------------------------------------------------
// seq_driver_if
//
// Bundles the control, status and downstream-FSM signals of seq_driver so the
// driver and whatever sits around it connect through one port.
//
// Parameters
//   GAP_W      width of the inter-symbol gap count
//   LAP_W      width of the lap request and lap counter
//
// Signals (direction as seen by the driver, modport slave)
//   start      in   one-cycle request to begin a run
//   stop       in   request to end the current run
//   gap_cycles in   idle cycles between emitted symbols
//   laps_req   in   number of 32-symbol laps to run, 0 = run until stop
//   dut_state  in   state read back from the downstream 32-state FSM
//   sym        out  symbol driven to the downstream FSM
//   sym_valid  out  high in a cycle that emits an advancing symbol
//   pos        out  expected downstream state
//   busy       out  high whenever the controller is not idle
//   lap_done   out  one-cycle pulse on each lap completion
//   laps_cnt   out  laps completed in the current run
//   mismatch   out  sticky readback-error flag
//   err_cnt    out  saturating readback-error count
// -----------------------------------------------------------------------------
interface seq_driver_if #(
    parameter int GAP_W = 4,
    parameter int LAP_W = 4
);
    logic             start;
    logic             stop;
    logic [GAP_W-1:0] gap_cycles;
    logic [LAP_W-1:0] laps_req;
    logic [4:0]       dut_state;
    logic [1:0]       sym;
    logic             sym_valid;
    logic [4:0]       pos;
    logic             busy;
    logic             lap_done;
    logic [LAP_W-1:0] laps_cnt;
    logic             mismatch;
    logic [7:0]       err_cnt;

    // Driver side.
    modport slave (
        input  start, stop, gap_cycles, laps_req, dut_state,
        output sym, sym_valid, pos, busy, lap_done, laps_cnt, mismatch, err_cnt
    );

    // Controlling side (test bench or system controller).
    modport master (
        output start, stop, gap_cycles, laps_req, dut_state,
        input  sym, sym_valid, pos, busy, lap_done, laps_cnt, mismatch, err_cnt
    );
endinterface : seq_driver_if

// File: rtl/seq_driver.sv
// -----------------------------------------------------------------------------
// seq_driver
//
// Walks a downstream 32-state sequence FSM around its ring. Each EMIT cycle
// drives the advancing symbol pos[1:0]; every other cycle drives the
// non-advancing symbol (pos[1:0]+2) mod 4. An optional gap of idle cycles
// separates emissions, and a run ends after a requested number of 32-symbol
// laps or on stop. pos tracks where the downstream FSM should be and survives
// between runs.
//
// Parameters
//   GAP_W      width of gap_cycles and of the gap counter
//   LAP_W      width of laps_req and laps_cnt (must match the interface)
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset; assertion is immediate,
//              release is synchronised to clk
//   bus        seq_driver_if.slave, see the interface for signal list
//
// Configuration
//   SEQ_DRV_CHECK_EN  when defined, dut_state is compared with pos in the
//                     cycle after every emission; differences set the sticky
//                     mismatch flag and bump the saturating err_cnt. When
//                     undefined, dut_state is ignored and both read 0.
// -----------------------------------------------------------------------------
module seq_driver #(
    parameter int GAP_W = 4,
    parameter int LAP_W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Reset synchroniser: assertion reaches the core immediately (the flops
    // clear asynchronously), release is delayed by two clk edges so the FSM
    // never sees a reset edge close to its clock.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [4:0]       pos_q;
    logic [GAP_W-1:0] gap_lat_q;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LAP_W-1:0] laps_lat_q;
    logic [LAP_W-1:0] laps_cnt_q, laps_cnt_d;
    logic             lap_done_q;

    logic             start_acc;
    logic             emit;
    logic             lap_wrap;
    logic [LAP_W-1:0] laps_next;

    // stop outranks start in IDLE; start is only looked at in IDLE, so it is
    // ignored for the whole of a run.
    assign start_acc = (state_q == IDLE) && bus.start && !bus.stop;
    assign emit      = (state_q == EMIT);
    assign lap_wrap  = emit && (pos_q == 5'd31);
    assign laps_next = laps_cnt_q + LAP_W'(lap_wrap);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        laps_cnt_d = laps_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d    = EMIT;
                    laps_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end

            EMIT: begin
                // The emission in progress always completes, including its
                // lap count, even when stop is asserted.
                laps_cnt_d = laps_next;
                if (bus.stop) begin
                    state_d = IDLE;
                end else if ((laps_lat_q != '0) && (laps_next == laps_lat_q)) begin
                    state_d = IDLE;
                end else if (gap_lat_q == '0) begin
                    state_d = EMIT;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_lat_q;
                end
            end

            GAP: begin
                // gap_cnt_q counts the remaining gap cycles including this one.
                if (bus.stop) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = EMIT;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            gap_lat_q  <= '0;
            laps_lat_q <= '0;
            gap_cnt_q  <= '0;
            laps_cnt_q <= '0;
            lap_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            laps_cnt_q <= laps_cnt_d;
            lap_done_q <= lap_wrap;
            if (emit) begin
                pos_q <= pos_q + 5'd1;
            end
            if (start_acc) begin
                gap_lat_q  <= bus.gap_cycles;
                laps_lat_q <= bus.laps_req;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded straight from registered state so the symbol lines up
    // with the cycle that pos describes.
    // -------------------------------------------------------------------------
    assign bus.sym       = emit ? pos_q[1:0] : (pos_q[1:0] + 2'd2);
    assign bus.sym_valid = emit;
    assign bus.pos       = pos_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.lap_done  = lap_done_q;
    assign bus.laps_cnt  = laps_cnt_q;

    // -------------------------------------------------------------------------
    // Optional readback checker
    // -------------------------------------------------------------------------
`ifdef SEQ_DRV_CHECK_EN
    logic       chk_pend_q;
    logic       mismatch_q;
    logic [7:0] err_cnt_q;

    // The downstream FSM advances on the same edge as pos, so one cycle after
    // an emission both should hold the same value.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            chk_pend_q <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            chk_pend_q <= emit;
            if (start_acc) begin
                // A new run starts clean; a check still pending from the
                // previous run's last emission is dropped with it.
                mismatch_q <= 1'b0;
                err_cnt_q  <= '0;
            end else if (chk_pend_q && (bus.dut_state != pos_q)) begin
                mismatch_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    // Readback is not used in this build.
    wire unused_dut_state = ^bus.dut_state;

    assign bus.mismatch = 1'b0;
    assign bus.err_cnt  = 8'd0;
`endif

endmodule : seq_driver

// File: tb/tb_seq_driver.sv
// -----------------------------------------------------------------------------
// tb_seq_driver
//
// Directed runs of seq_driver with a scoreboard: each run pushes the symbols
// it should produce into a queue, and an independent monitor pops one entry
// per sym_valid cycle, checking sym, pos, the lap_done pulse that follows a
// pos==31 emission and the non-advancing symbol on every other cycle.
// A small model of the downstream FSM drives dut_state.
// -----------------------------------------------------------------------------
module tb_seq_driver;

    localparam int GAP_W = 4;
    localparam int LAP_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    seq_driver_if #(.GAP_W(GAP_W), .LAP_W(LAP_W)) bus ();

    seq_driver #(.GAP_W(GAP_W), .LAP_W(LAP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [1:0] sym;
        logic [4:0] pos;
        logic       lap;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   lap_pulses  = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Downstream 32-state FSM model; force_err makes it read back one ahead.
    logic [4:0] down_state;
    logic       force_err = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            down_state <= 5'd0;
        end else if (bus.sym_valid) begin
            down_state <= down_state + 5'd1;
        end
    end

    assign bus.dut_state = force_err ? (down_state + 5'd1) : down_state;

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin : monitor
        logic [4:0] exp_pos;
        logic [1:0] exp_idle;
        logic       prev_lap;
        exp_t       it;
        exp_pos  = 5'd0;
        prev_lap = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_pos  = 5'd0;
                prev_lap = 1'b0;
            end else begin
                check("lap_done", bus.lap_done, prev_lap);
                if (bus.lap_done) lap_pulses++;
                prev_lap = 1'b0;
                if (bus.sym_valid) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_emit: sym_valid=1 pos=%0d, expected no emission",
                                 bus.pos);
                    end else begin
                        it = sb_q.pop_front();
                        check("emit_sym", bus.sym, it.sym);
                        check("emit_pos", bus.pos, it.pos);
                        exp_pos  = it.pos + 5'd1;
                        prev_lap = it.lap;
                    end
                end else begin
                    exp_idle = exp_pos[1:0] + 2'd2;
                    check("idle_sym", bus.sym, exp_idle);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int p0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int p;
            p     = (p0 + k) % 32;
            e.sym = p[1:0];
            e.pos = p[4:0];
            e.lap = (p == 31);
            sb_q.push_back(e);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepts start,
    // i.e. in the first EMIT cycle.
    task automatic start_run(input int gap, input int laps);
        bus.gap_cycles = gap[GAP_W-1:0];
        bus.laps_req   = laps[LAP_W-1:0];
        bus.start      = 1'b1;
        step(1);
        bus.start      = 1'b0;
    endtask

    // Counts busy cycles from the current cycle; returns at the negedge of the
    // first idle cycle.
    task automatic wait_idle(output int n, input int limit);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (n > limit) begin
                vectors++;
                miscompares++;
                $display("FAIL busy_timeout: still busy after %0d cycles, expected idle", n);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sym"},       bus.sym, 2'b10);
        check({tag, "_sym_valid"}, bus.sym_valid, 0);
        check({tag, "_pos"},       bus.pos, 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_lap_done"},  bus.lap_done, 0);
        check({tag, "_laps_cnt"},  bus.laps_cnt, 0);
        check({tag, "_mismatch"},  bus.mismatch, 0);
        check({tag, "_err_cnt"},   bus.err_cnt, 0);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin : stimulus
        int n;
        int lp0;

        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.gap_cycles = '0;
        bus.laps_req   = '0;

        // Reset state.
        #2;
        check_reset_outputs("reset");
        step(2);
        reset_n = 1'b1;
        step(3);

        // gap=0, laps=1: 32 back-to-back emissions, one lap.
        push_run(0, 32);
        lp0 = lap_pulses;
        start_run(0, 1);
        wait_idle(n, 100);
        check("g0_run_len", n, 32);
        step(1);
        check("g0_pos", bus.pos, 0);
        check("g0_laps_cnt", bus.laps_cnt, 1);
        check("g0_lap_pulses", lap_pulses - lp0, 1);
        check("g0_drain", sb_q.size(), 0);

        // gap=2, laps=1: 32 emissions + 31*2 gap cycles.
        push_run(0, 32);
        lp0 = lap_pulses;
        start_run(2, 1);
        wait_idle(n, 300);
        check("g2_run_len", n, 94);
        step(1);
        check("g2_pos", bus.pos, 0);
        check("g2_laps_cnt", bus.laps_cnt, 1);
        check("g2_lap_pulses", lap_pulses - lp0, 1);
        check("g2_drain", sb_q.size(), 0);

        // laps=0: 70 emissions, a start (with new gap) ignored mid-run, stop.
        push_run(0, 70);
        lp0 = lap_pulses;
        start_run(0, 0);
        step(19);
        bus.start      = 1'b1;
        bus.gap_cycles = 4'd5;
        step(1);
        bus.start      = 1'b0;
        bus.gap_cycles = '0;
        step(49);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        @(negedge clk);
        check("free_busy", bus.busy, 0);
        step(1);
        check("free_pos", bus.pos, 6);
        check("free_laps_cnt", bus.laps_cnt, 2);
        check("free_lap_pulses", lap_pulses - lp0, 2);
        check("free_drain", sb_q.size(), 0);

        // Reset asserted during GAP: outputs clear before the next edge.
        push_run(6, 2);
        start_run(3, 0);
        step(5);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_drain", sb_q.size(), 0);
        step(2);
        reset_n = 1'b1;
        step(6);
        check("midrst_busy_after", bus.busy, 0);
        check("midrst_pos_after", bus.pos, 0);

        // stop during GAP: emissions at pos 0,1,2 then idle.
        push_run(0, 3);
        start_run(3, 0);
        step(9);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        @(negedge clk);
        check("gapstop_busy", bus.busy, 0);
        step(4);
        check("gapstop_pos", bus.pos, 3);
        check("gapstop_drain", sb_q.size(), 0);

        // stop during the EMIT of pos 5: emission completes, pos=6.
        push_run(3, 3);
        start_run(0, 0);
        step(2);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        @(negedge clk);
        check("emitstop_busy", bus.busy, 0);
        check("emitstop_pos", bus.pos, 6);
        check("emitstop_drain", sb_q.size(), 0);

        // start and stop together in IDLE: stop wins.
        step(1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);
        check("startstop_busy", bus.busy, 0);
        check("startstop_pos", bus.pos, 6);

        // Readback error after one emission, then cleared by a new start.
        step(1);
        push_run(6, 1);
        start_run(0, 0);
        bus.stop  = 1'b1;
        force_err = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(1);
        @(negedge clk);
`ifdef SEQ_DRV_CHECK_EN
        check("chk_mismatch", bus.mismatch, 1);
        check("chk_err_cnt", bus.err_cnt, 1);
`else
        check("chk_mismatch", bus.mismatch, 0);
        check("chk_err_cnt", bus.err_cnt, 0);
`endif
        force_err = 1'b0;
        step(1);
        push_run(7, 1);
        start_run(0, 0);
        bus.stop = 1'b1;
        @(negedge clk);
        check("clr_mismatch", bus.mismatch, 0);
        check("clr_err_cnt", bus.err_cnt, 0);
        step(1);
        bus.stop = 1'b0;
        step(2);
        check("clr_mismatch_after", bus.mismatch, 0);
        check("clr_pos", bus.pos, 8);
        check("clr_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule : tb_seq_driver

// File: doc/seq_driver.md
SEQ_DRIVER -- requirements
Module: seq_driver

Interface
REQ-001 The module SHALL have parameter GAP_W, default 4, giving the width of the inter-symbol gap count.
REQ-002 The module SHALL have parameter LAP_W, default 4, giving the width of the lap request and lap counter.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge only.
REQ-004 The module SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit, a one-cycle request to begin a run.
REQ-006 The module SHALL have port stop, input, 1 bit, a request to end the current run.
REQ-007 The module SHALL have port gap_cycles, input, GAP_W bits, the number of idle cycles between emitted symbols.
REQ-008 The module SHALL have port laps_req, input, LAP_W bits, the number of 32-symbol laps to run; 0 means run until stop.
REQ-009 The module SHALL have port dut_state, input, 5 bits, the state read back from the downstream 32-state sequence FSM.
REQ-010 The module SHALL have port sym, output, 2 bits, the symbol driven to the downstream FSM input.
REQ-011 The module SHALL have port sym_valid, output, 1 bit, high in a cycle that emits an advancing symbol.
REQ-012 The module SHALL have port pos, output, 5 bits, the expected downstream state.
REQ-013 The module SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-014 The module SHALL have port lap_done, output, 1 bit, a one-cycle pulse on each lap completion.
REQ-015 The module SHALL have port laps_cnt, output, LAP_W bits, the number of laps completed in the current run.
REQ-016 The module SHALL have port mismatch, output, 1 bit, a sticky readback-error flag.
REQ-017 The module SHALL have port err_cnt, output, 8 bits, a saturating count of readback errors.

Function
REQ-018 The controller SHALL have exactly three states, IDLE, EMIT and GAP, and SHALL reset to IDLE.
REQ-019 In IDLE, a start sampled high SHALL latch gap_cycles and laps_req, clear laps_cnt, and move the FSM to EMIT on the next cycle.
REQ-020 In EMIT, sym SHALL equal pos[1:0] and sym_valid SHALL be 1; pos SHALL increment modulo 32 at the end of that cycle.
REQ-021 In every cycle other than EMIT, sym SHALL be (pos[1:0]+2) mod 4 (a non-advancing symbol) and sym_valid SHALL be 0.
REQ-022 sym and sym_valid SHALL be decoded from the registered FSM state and pos with no additional cycle of latency.
REQ-023 When an EMIT occurs with pos==31, laps_cnt SHALL increment and lap_done SHALL pulse high for exactly the following cycle.
REQ-024 After EMIT, the FSM SHALL go to IDLE if laps_req is nonzero and the updated laps_cnt equals it; otherwise it SHALL go to EMIT if the latched gap is 0, or to GAP if it is nonzero.
REQ-025 GAP SHALL last exactly the latched gap number of cycles and then return to EMIT.
REQ-026 stop SHALL take effect as follows: in GAP, the FSM SHALL go to IDLE on the next cycle; in EMIT, the emission SHALL complete and the FSM SHALL then go to IDLE; in IDLE, stop SHALL win over a simultaneous start.
REQ-027 start SHALL be ignored while busy is 1.
REQ-028 pos SHALL persist across runs and SHALL be cleared only by reset_n.
REQ-029 laps_cnt SHALL wrap modulo 2^LAP_W when laps_req is 0.

Reset
REQ-030 While reset_n is low, the following SHALL hold immediately and independently of clk: FSM=IDLE, pos=0, sym=2'b10, sym_valid=0, busy=0, lap_done=0, laps_cnt=0, mismatch=0, err_cnt=0, gap counter=0.
REQ-031 Assertion of reset_n mid-run SHALL abort the run with no further emissions.
REQ-032 Release of reset_n SHALL be synchronised to clk before it is used by the FSM.

Configuration
REQ-033 When macro SEQ_DRV_CHECK_EN is defined, the module SHALL compare dut_state with pos in the cycle after every EMIT; on a difference it SHALL set mismatch and increment err_cnt, saturating at 255.
REQ-034 When SEQ_DRV_CHECK_EN is defined, mismatch and err_cnt SHALL be cleared only by reset_n or by an accepted start.
REQ-035 When SEQ_DRV_CHECK_EN is undefined, dut_state SHALL be ignored and mismatch and err_cnt SHALL be tied to 0.

Verification
REQ-036 Reset then start with gap=0 and laps=1 SHALL produce 32 consecutive sym_valid cycles with sym sequence 0,1,2,3 repeating, a lap_done pulse one cycle after the 32nd emission, then busy=0, pos=0 and laps_cnt=1.
REQ-037 With gap=2 and laps=1, sym_valid SHALL be high every third cycle, each gap cycle SHALL show sym=(pos[1:0]+2) mod 4, and the run SHALL last 94 cycles.
REQ-038 stop during GAP SHALL give busy=0 on the next cycle with no further sym_valid; stop during an EMIT with pos=5 SHALL complete that emission and leave pos=6 in IDLE.
REQ-039 With laps=0 and 70 emissions followed by stop, the bench SHALL observe pos 31->0 wrap twice, two lap_done pulses, laps_cnt=2 and pos=6.
REQ-040 With SEQ_DRV_CHECK_EN defined and dut_state forced to pos+1 after one emission, mismatch SHALL be 1 and err_cnt 1; a subsequent start SHALL clear both.
REQ-041 reset_n pulsed low during GAP SHALL drive every output to its REQ-030 reset value before the next clk edge.
